// File: rtl/atm_bank_ledger_pkg.sv
// Shared definitions for the ATM bank ledger: op codes, status codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atm_bank_ledger_pkg;

  localparam int ACC_W = 4;
  localparam int PIN_W = 16;
  localparam int AMT_W = 16;
  localparam int BAL_W = 16;

  // BALANCE/WITHDRAW/DEPOSIT/CHANGE_PIN keep the controller's existing values
  typedef enum logic [2:0] {
    OP_AUTH       = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_CHANGE_PIN = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    STS_OK           = 3'd0,
    STS_BAD_ACC      = 3'd1,
    STS_BAD_PIN      = 3'd2,
    STS_LOCKED       = 3'd3,
    STS_INSUFFICIENT = 3'd4,
    STS_OVERFLOW     = 3'd5,
    STS_BAD_OP       = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Request fields captured at acceptance; later input changes are ignored
  typedef struct packed {
    logic [2:0]       op;
    logic [ACC_W-1:0] acc;
    logic [PIN_W-1:0] pin;
    logic [PIN_W-1:0] new_pin;
    logic [AMT_W-1:0] amount;
  } req_t;

endpackage

// File: rtl/atm_fail_tracker.sv
// Per-account consecutive wrong-PIN counters and sticky lock bits.
// Latency: locked is combinational from idx; fail/pass pulses update on the next edge.
// Backpressure: none; the owner pulses fail/pass at most once per transaction.
module atm_fail_tracker
  import atm_bank_ledger_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int MAX_FAIL     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] idx,
  input  logic             fail,
  input  logic             pass,
  output logic             locked
);

  logic [1:0] cnt_q  [NUM_ACCOUNTS];
  logic [1:0] cnt_d  [NUM_ACCOUNTS];
  logic       lock_q [NUM_ACCOUNTS];
  logic       lock_d [NUM_ACCOUNTS];
  logic       idx_ok;
  logic [1:0] cnt_inc;

  assign idx_ok  = ({{(32-ACC_W){1'b0}}, idx} < NUM_ACCOUNTS);
  assign locked  = idx_ok ? lock_q[idx] : 1'b0;
  assign cnt_inc = idx_ok ? (cnt_q[idx] + 2'd1) : 2'd0;

  // Next counter/lock state: a failure that reaches MAX_FAIL locks in the same update
  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (idx_ok) begin
      if (fail) begin
        cnt_d[idx] = cnt_inc;
        if (cnt_inc == 2'(MAX_FAIL)) begin
          lock_d[idx] = 1'b1;
        end
      end else if (pass) begin
        cnt_d[idx] = 2'd0;
      end
    end
  end

  // Counter and lock registers; locks are only cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        cnt_q[i]  <= 2'd0;
        lock_q[i] <= 1'b0;
      end
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/atm_bank_ledger.sv
// Bank ledger: authenticates and executes one ATM request at a time against the account database.
// Latency: request accepted at edge k gives rsp_valid after edge k+3; one transaction per 5 cycles.
// Backpressure: response held stable while rsp_ready=0; req_ready only high in IDLE.
module atm_bank_ledger
  import atm_bank_ledger_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int INIT_BALANCE = 500,
  parameter int PIN_BASE     = 1000,
  parameter int MAX_FAIL     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [ACC_W-1:0] req_acc,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [PIN_W-1:0] req_new_pin,
  input  logic [AMT_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  status_e          auth_q, auth_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_status_q, rsp_status_d;
  logic [BAL_W-1:0] rsp_balance_q, rsp_balance_d;
  logic [BAL_W-1:0] bal_q [NUM_ACCOUNTS];
  logic [BAL_W-1:0] bal_d [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_d [NUM_ACCOUNTS];

  logic             acc_ok;
  logic [ACC_W-1:0] idx;
  logic [BAL_W-1:0] cur_bal;
  logic             pin_ok;
  logic             locked;
  logic             fail_pulse;
  logic             pass_pulse;
  logic [BAL_W:0]   sum17;

  // Out-of-range accounts are steered to entry 0 so array reads stay in bounds
  assign acc_ok  = ({{(32-ACC_W){1'b0}}, req_q.acc} < NUM_ACCOUNTS);
  assign idx     = acc_ok ? req_q.acc : '0;
  assign cur_bal = bal_q[idx];
  assign pin_ok  = (req_q.pin == pin_q[idx]);
  assign sum17   = {1'b0, cur_bal} + {1'b0, req_q.amount};

  // Fail/pass only count for a valid, unlocked account during authentication
  assign fail_pulse = (state_q == S_CHECK) && acc_ok && !locked && !pin_ok;
  assign pass_pulse = (state_q == S_CHECK) && acc_ok && !locked &&  pin_ok;

  atm_fail_tracker #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .MAX_FAIL     (MAX_FAIL)
  ) u_fail_tracker (
    .clk    (clk),
    .rst    (rst),
    .idx    (req_q.acc),
    .fail   (fail_pulse),
    .pass   (pass_pulse),
    .locked (locked)
  );

  // Outputs are forced quiet in any cycle where reset is asserted
  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign rsp_valid   = rsp_valid_q && !rst;
  assign rsp_status  = rst ? 3'd0 : rsp_status_q;
  assign rsp_balance = rst ? '0 : rsp_balance_q;

  // Next-state: capture, authenticate, commit, then present the response
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    auth_d        = auth_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_balance_d = rsp_balance_q;
    bal_d         = bal_q;
    pin_d         = pin_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.op      = req_op;
          req_d.acc     = req_acc;
          req_d.pin     = req_pin;
          req_d.new_pin = req_new_pin;
          req_d.amount  = req_amount;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!acc_ok)      auth_d = STS_BAD_ACC;
        else if (locked)  auth_d = STS_LOCKED;
        else if (!pin_ok) auth_d = STS_BAD_PIN;
        else              auth_d = STS_OK;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Failed authentication reports balance 0 so nothing leaks
        if (auth_q != STS_OK) begin
          rsp_status_d  = auth_q;
          rsp_balance_d = '0;
        end else begin
          rsp_status_d  = STS_OK;
          rsp_balance_d = cur_bal;
          case (req_q.op)
            OP_AUTH, OP_BALANCE: ;
            OP_WITHDRAW: begin
              if (req_q.amount > cur_bal) begin
                rsp_status_d = STS_INSUFFICIENT;
              end else begin
                bal_d[idx]    = cur_bal - req_q.amount;
                rsp_balance_d = cur_bal - req_q.amount;
              end
            end
            OP_DEPOSIT: begin
              if (sum17[BAL_W]) begin
                rsp_status_d = STS_OVERFLOW;
              end else begin
                bal_d[idx]    = sum17[BAL_W-1:0];
                rsp_balance_d = sum17[BAL_W-1:0];
              end
            end
            OP_CHANGE_PIN: pin_d[idx] = req_q.new_pin;
            default:       rsp_status_d = STS_BAD_OP;
          endcase
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        // rsp_valid rises one cycle after entering RESP
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset restores the account database and abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      auth_q        <= STS_OK;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= 3'd0;
      rsp_balance_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i] <= BAL_W'(INIT_BALANCE);
        pin_q[i] <= PIN_W'(PIN_BASE + i);
      end
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      auth_q        <= auth_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_balance_q <= rsp_balance_d;
      bal_q         <= bal_d;
      pin_q         <= pin_d;
    end
  end

endmodule
